// File: rtl/fp_to_tc.sv
// Iterative FP {s,e,f} -> two's-complement decoder: one exponent step per clock,
// valid/ready handshakes on both the FP input and the integer output.
module fp_to_tc #(
    parameter int W_D = 12,
    parameter int W_E = 3,
    parameter int W_F = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s,
    input  logic [W_E-1:0] e,
    input  logic [W_F-1:0] f,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W_D-1:0] d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           nonnorm
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         r_state;
    logic [W_D-1:0] r_mag;
    logic [W_E-1:0] r_cnt;
    logic           r_sign;
    logic           r_nonnorm_n;
    logic [W_D-1:0] r_d;
    logic           r_out_valid;
    logic           r_nonnorm;
    logic           r_in_ready;

    // in_ready is a register so it stays low throughout reset and rises on the
    // first edge after release, rather than following the IDLE state directly.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_nonnorm_n <= 1'b0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_nonnorm   <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_sign      <= s;
                        r_mag       <= {{(W_D-W_F){1'b0}}, f};
                        r_cnt       <= e;
                        r_nonnorm_n <= (f != '0) && !f[W_F-1];
                        r_in_ready  <= 1'b0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt - W_E'(1);
                    end else begin
                        r_d         <= r_sign ? (~r_mag + W_D'(1)) : r_mag;
                        r_nonnorm   <= r_nonnorm_n;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign d         = r_d;
    assign out_valid = r_out_valid;
    assign nonnorm   = r_nonnorm;

endmodule

// File: tb/tb_fp_to_tc.sv
// Scoreboard bench for fp_to_tc: expected results are queued at accept and
// popped by an independent monitor on every output handshake.
module tb_fp_to_tc;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] d;
    logic        out_valid;
    logic        out_ready;
    logic        nonnorm;

    typedef struct {
        logic [11:0] d;
        logic        nn;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_acc     = 0;
    int   n_flushed = 0;
    int   n_out     = 0;
    bit   rand_ready = 0;

    fp_to_tc #(.W_D(12), .W_E(3), .W_F(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .e         (e),
        .f         (f),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nonnorm   (nonnorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: d = (-1)^s * f * 2^e in plain integer arithmetic, kept to 12 bits.
    function automatic exp_t model(input logic si, input logic [2:0] ei, input logic [3:0] fi);
        exp_t r;
        int   mag;
        int   v;
        mag  = int'(fi) * (1 << ei);
        v    = si ? -mag : mag;
        r.d  = v[11:0];
        r.nn = (fi != 0) && (fi < 8);
        return r;
    endfunction

    // Monitor: out_valid && out_ready at a falling edge means a handshake on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(d), 32'hffff_ffff);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("sb_d", 32'(d), 32'(x.d));
                check("sb_nonnorm", 32'(nonnorm), 32'(x.nn));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called aligned to #1 after a rising edge; returns aligned the same way.
    task automatic do_accept(input logic si, input logic [2:0] ei, input logic [3:0] fi, input bit hold);
        s        = si;
        e        = ei;
        f        = fi;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                sb.push_back(model(si, ei, fi));
                n_acc++;
                if (!hold) in_valid = 1'b0;
                s = 1'($urandom);
                e = 3'($urandom);
                f = 4'($urandom);
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept until out_valid is seen; returns at a falling edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) return;
            @(posedge clk);
            #1;
            lat++;
        end
        lat = -1;
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic si, input logic [2:0] ei, input logic [3:0] fi,
                           input logic [11:0] lit_d, input logic lit_nn, input string tag);
        int lat;
        do_accept(si, ei, fi, 1'b0);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(ei) + 32'd1);
        check({tag, "_d"}, 32'(d), 32'(lit_d));
        check({tag, "_nonnorm"}, 32'(nonnorm), 32'(lit_nn));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s = 1'b0; e = '0; f = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_nonnorm", 32'(nonnorm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        run_one(1'b0, 3'd3, 4'b1011, 12'h058, 1'b0, "t1");
        run_one(1'b1, 3'd7, 4'b1111, 12'h880, 1'b0, "t2a");
        run_one(1'b0, 3'd0, 4'b1000, 12'h008, 1'b0, "t2b");
        run_one(1'b1, 3'd5, 4'b0000, 12'h000, 1'b0, "t3a");
        run_one(1'b0, 3'd2, 4'b0101, 12'h014, 1'b1, "t3b");

        // Backpressure: -12*16 = -192 held while the consumer stalls.
        out_ready = 1'b0;
        do_accept(1'b1, 3'd4, 4'b1100, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd5);
        repeat (6) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_d", 32'(d), 32'h0000_0f40);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset two cycles into a long shift discards the conversion.
        out_ready = 1'b1;
        do_accept(1'b0, 3'd6, 4'b1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_d", 32'(d), 32'd0);
        check("mid_reset_in_ready", 32'(in_ready), 32'd0);
        n_flushed += sb.size();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_release_in_ready", 32'(in_ready), 32'd1);
        check("mid_reset_release_out_valid", 32'(out_valid), 32'd0);
        run_one(1'b0, 3'd1, 4'b1001, 12'h012, 1'b0, "t5");

        // Back-to-back random traffic with random consumer stalls.
        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            do_accept(1'($urandom), 3'($urandom), 4'($urandom), 1'b1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 1000 && sb.size() > 0; k++) begin
            @(posedge clk);
        end
        rand_ready = 0;
        #2;
        out_ready = 1'b1;
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        check("output_count", 32'(n_out), 32'(n_acc - n_flushed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
